// File: rtl/hsv_share_arbiter.sv
// Round-robin share of one pipelined rgb2hsv converter between requesters A and B.
// Latency LATENCY+2 from accept to result strobe; readiness is gated by enable only, results are never backpressured.
module hsv_share_arbiter #(
    parameter int LATENCY = 22,
    parameter int TAG_W   = 20
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             a_valid_i,
    input  logic [23:0]      a_rgb_i,
    input  logic [TAG_W-1:0] a_tag_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [23:0]      b_rgb_i,
    input  logic [TAG_W-1:0] b_tag_i,
    output logic             b_ready_o,
    output logic [7:0]       cv_r_o,
    output logic [7:0]       cv_g_o,
    output logic [7:0]       cv_b_o,
    input  logic [7:0]       cv_h_i,
    input  logic [7:0]       cv_s_i,
    input  logic [7:0]       cv_v_i,
    output logic             a_out_valid_o,
    output logic             b_out_valid_o,
    output logic [7:0]       out_h_o,
    output logic [7:0]       out_s_o,
    output logic [7:0]       out_v_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [5:0]       inflight_o,
    output logic             idle_o
);

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    logic             a_gnt;
    logic             b_gnt;
    logic             xfer;
    logic             last_q;
    logic             last_d;
    logic [23:0]      rgb_d;
    logic [23:0]      rgb_q;
    logic             iss_vld_q;
    logic             iss_id_q;
    logic [TAG_W-1:0] iss_tag_q;
    logic [LATENCY:1] dly_vld_q;
    logic [LATENCY:1] dly_id_q;
    logic [TAG_W-1:0] dly_tag_q [1:LATENCY];
    logic             ret_vld;
    logic             ret_id;
    logic             a_out_q;
    logic             b_out_q;
    logic [23:0]      hsv_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [6:0]       cnt_q;
    logic [6:0]       cnt_d;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (enable_i) begin
            if (a_valid_i && b_valid_i) begin
                a_gnt = (last_q == ID_B);
                b_gnt = (last_q == ID_A);
            end else begin
                a_gnt = a_valid_i;
                b_gnt = b_valid_i;
            end
        end
    end

    assign xfer   = a_gnt | b_gnt;
    assign last_d = xfer ? b_gnt : last_q;
    assign rgb_d  = b_gnt ? b_rgb_i : (a_gnt ? a_rgb_i : 24'd0);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_q    <= ID_B;
            rgb_q     <= '0;
            iss_vld_q <= 1'b0;
            iss_id_q  <= ID_A;
            iss_tag_q <= '0;
        end else begin
            last_q    <= last_d;
            rgb_q     <= rgb_d;
            iss_vld_q <= xfer;
            iss_id_q  <= b_gnt;
            iss_tag_q <= b_gnt ? b_tag_i : a_tag_i;
        end
    end

    // The converter cannot stall, so the matched delay line shifts every clock.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dly_vld_q <= '0;
        end else begin
            dly_vld_q <= {dly_vld_q[LATENCY-1:1], iss_vld_q};
        end
    end

    always_ff @(posedge clock_i) begin
        dly_id_q     <= {dly_id_q[LATENCY-1:1], iss_id_q};
        dly_tag_q[1] <= iss_tag_q;
        for (int k = 2; k <= LATENCY; k++) begin
            dly_tag_q[k] <= dly_tag_q[k-1];
        end
    end

    assign ret_vld = dly_vld_q[LATENCY];
    assign ret_id  = dly_id_q[LATENCY];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_out_q   <= 1'b0;
            b_out_q   <= 1'b0;
            hsv_q     <= '0;
            out_tag_q <= '0;
        end else begin
            a_out_q <= ret_vld && (ret_id == ID_A);
            b_out_q <= ret_vld && (ret_id == ID_B);
            if (ret_vld) begin
                hsv_q     <= {cv_h_i, cv_s_i, cv_v_i};
                out_tag_q <= dly_tag_q[LATENCY];
            end
        end
    end

    assign cnt_d = cnt_q + {6'd0, xfer} - {6'd0, ret_vld};

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign a_ready_o     = a_gnt;
    assign b_ready_o     = b_gnt;
    assign cv_r_o        = rgb_q[23:16];
    assign cv_g_o        = rgb_q[15:8];
    assign cv_b_o        = rgb_q[7:0];
    assign a_out_valid_o = a_out_q;
    assign b_out_valid_o = b_out_q;
    assign out_h_o       = hsv_q[23:16];
    assign out_s_o       = hsv_q[15:8];
    assign out_v_o       = hsv_q[7:0];
    assign out_tag_o     = out_tag_q;
    // Only LATENCY=63 can reach 64 in flight; the 6-bit view pins at 63 there.
    assign inflight_o    = cnt_q[6] ? 6'h3F : cnt_q[5:0];
    assign idle_o        = (cnt_q == 7'd0) && !xfer;

endmodule

// File: tb/tb_hsv_share_arbiter.sv
// Bench for hsv_share_arbiter: three latency instances on shared inputs, event-queue reference model.
module tb_hsv_share_arbiter;

    localparam int TAG_W = 20;
    localparam int NI    = 3;

    function automatic int lat(input int i);
        case (i)
            0:       return 22;
            1:       return 2;
            default: return 63;
        endcase
    endfunction

    function automatic logic [7:0] fh(input int c); return 8'(c * 37 + 11); endfunction
    function automatic logic [7:0] fs(input int c); return 8'(c * 13 + 5);  endfunction
    function automatic logic [7:0] fv(input int c); return 8'(c) ^ 8'hA5;   endfunction

    logic             clock = 1'b0;
    logic             reset_n, en, av, bv;
    logic [23:0]      argb, brgb;
    logic [TAG_W-1:0] atag, btag;
    logic [7:0]       cvh, cvs, cvv;

    logic             a_rdy_w [NI];
    logic             b_rdy_w [NI];
    logic [7:0]       cvr_w [NI];
    logic [7:0]       cvg_w [NI];
    logic [7:0]       cvb_w [NI];
    logic             aov_w [NI];
    logic             bov_w [NI];
    logic [7:0]       oh_w [NI];
    logic [7:0]       os_w [NI];
    logic [7:0]       ov_w [NI];
    logic [TAG_W-1:0] otag_w [NI];
    logic [5:0]       infl_w [NI];
    logic             idle_w [NI];

    always #5 clock = ~clock;

    hsv_share_arbiter #(.LATENCY(22), .TAG_W(TAG_W)) u0 (
        .clock_i(clock), .reset_ni(reset_n), .enable_i(en),
        .a_valid_i(av), .a_rgb_i(argb), .a_tag_i(atag), .a_ready_o(a_rdy_w[0]),
        .b_valid_i(bv), .b_rgb_i(brgb), .b_tag_i(btag), .b_ready_o(b_rdy_w[0]),
        .cv_r_o(cvr_w[0]), .cv_g_o(cvg_w[0]), .cv_b_o(cvb_w[0]),
        .cv_h_i(cvh), .cv_s_i(cvs), .cv_v_i(cvv),
        .a_out_valid_o(aov_w[0]), .b_out_valid_o(bov_w[0]),
        .out_h_o(oh_w[0]), .out_s_o(os_w[0]), .out_v_o(ov_w[0]), .out_tag_o(otag_w[0]),
        .inflight_o(infl_w[0]), .idle_o(idle_w[0]));

    hsv_share_arbiter #(.LATENCY(2), .TAG_W(TAG_W)) u1 (
        .clock_i(clock), .reset_ni(reset_n), .enable_i(en),
        .a_valid_i(av), .a_rgb_i(argb), .a_tag_i(atag), .a_ready_o(a_rdy_w[1]),
        .b_valid_i(bv), .b_rgb_i(brgb), .b_tag_i(btag), .b_ready_o(b_rdy_w[1]),
        .cv_r_o(cvr_w[1]), .cv_g_o(cvg_w[1]), .cv_b_o(cvb_w[1]),
        .cv_h_i(cvh), .cv_s_i(cvs), .cv_v_i(cvv),
        .a_out_valid_o(aov_w[1]), .b_out_valid_o(bov_w[1]),
        .out_h_o(oh_w[1]), .out_s_o(os_w[1]), .out_v_o(ov_w[1]), .out_tag_o(otag_w[1]),
        .inflight_o(infl_w[1]), .idle_o(idle_w[1]));

    hsv_share_arbiter #(.LATENCY(63), .TAG_W(TAG_W)) u2 (
        .clock_i(clock), .reset_ni(reset_n), .enable_i(en),
        .a_valid_i(av), .a_rgb_i(argb), .a_tag_i(atag), .a_ready_o(a_rdy_w[2]),
        .b_valid_i(bv), .b_rgb_i(brgb), .b_tag_i(btag), .b_ready_o(b_rdy_w[2]),
        .cv_r_o(cvr_w[2]), .cv_g_o(cvg_w[2]), .cv_b_o(cvb_w[2]),
        .cv_h_i(cvh), .cv_s_i(cvs), .cv_v_i(cvv),
        .a_out_valid_o(aov_w[2]), .b_out_valid_o(bov_w[2]),
        .out_h_o(oh_w[2]), .out_s_o(os_w[2]), .out_v_o(ov_w[2]), .out_tag_o(otag_w[2]),
        .inflight_o(infl_w[2]), .idle_o(idle_w[2]));

    // One expected result per accepted pixel per instance, due on a known cycle.
    typedef struct {
        int               inst;
        int               due;
        bit               id;
        logic [TAG_W-1:0] tag;
        logic [23:0]      hsv;
    } ev_t;

    typedef struct {
        bit en;
        bit av;
        bit bv;
        bit ea;
        bit eb;
    } vec_t;

    ev_t         evq[$];
    vec_t        tbl[12];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_last = 1'b1;
    logic [23:0] exp_cv = '0;
    int          a_cnt[NI], b_cnt[NI], a_seen[NI], max_infl[NI];
    bit          smp_a, smp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < NI; i++) begin
            a_cnt[i] = 0; b_cnt[i] = 0; a_seen[i] = -1; max_infl[i] = 0;
        end
    endtask

    task automatic monitor();
        bit  ga, gb;
        int  n, idx;
        ev_t e;
        ga = en && av && (!bv || m_last);
        gb = en && bv && (!av || !m_last);
        smp_a = a_rdy_w[0];
        smp_b = b_rdy_w[0];
        for (int i = 0; i < NI; i++) begin
            n = 0;
            idx = -1;
            for (int k = 0; k < evq.size(); k++) begin
                if (evq[k].inst == i) begin
                    if (evq[k].due > cyc) n++;
                    if (idx < 0) idx = k;
                end
            end
            chk($sformatf("inflight[%0d]", i), 32'(infl_w[i]), (n > 63) ? 63 : n);
            if (int'(infl_w[i]) > max_infl[i]) max_infl[i] = int'(infl_w[i]);
            chk($sformatf("idle[%0d]", i), 32'(idle_w[i]), 32'(n == 0 && !ga && !gb));
            chk($sformatf("a_ready[%0d]", i), 32'(a_rdy_w[i]), 32'(ga));
            chk($sformatf("b_ready[%0d]", i), 32'(b_rdy_w[i]), 32'(gb));
            chk($sformatf("cv_rgb[%0d]", i), 32'({cvr_w[i], cvg_w[i], cvb_w[i]}), 32'(exp_cv));
            if (idx >= 0 && evq[idx].due == cyc) begin
                e = evq[idx];
                evq.delete(idx);
                chk($sformatf("a_strobe[%0d]", i), 32'(aov_w[i]), 32'(!e.id));
                chk($sformatf("b_strobe[%0d]", i), 32'(bov_w[i]), 32'(e.id));
                chk($sformatf("out_tag[%0d]", i), 32'(otag_w[i]), 32'(e.tag));
                chk($sformatf("out_hsv[%0d]", i), 32'({oh_w[i], os_w[i], ov_w[i]}), 32'(e.hsv));
            end else begin
                chk($sformatf("a_strobe_idle[%0d]", i), 32'(aov_w[i]), 32'd0);
                chk($sformatf("b_strobe_idle[%0d]", i), 32'(bov_w[i]), 32'd0);
            end
            if (aov_w[i]) begin a_cnt[i]++; a_seen[i] = cyc; end
            if (bov_w[i]) b_cnt[i]++;
        end
        if (ga || gb) begin
            for (int i = 0; i < NI; i++) begin
                e.inst = i;
                e.due  = cyc + 2 + lat(i);
                e.id   = gb;
                e.tag  = gb ? btag : atag;
                e.hsv  = {fh(cyc + 1 + lat(i)), fs(cyc + 1 + lat(i)), fv(cyc + 1 + lat(i))};
                evq.push_back(e);
            end
            m_last = gb;
            exp_cv = gb ? brgb : argb;
        end else begin
            exp_cv = '0;
        end
    endtask

    // Called just after a rising edge with inputs already set for this cycle.
    task automatic run_cycle();
        cvh = fh(cyc);
        cvs = fs(cyc);
        cvv = fv(cyc);
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        av = 1'b0; bv = 1'b0; en = 1'b1;
        repeat (n) run_cycle();
    endtask

    task automatic do_reset();
        av = 1'b0; bv = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_a_strobe[%0d]", i), 32'(aov_w[i]), 32'd0);
            chk($sformatf("rst_b_strobe[%0d]", i), 32'(bov_w[i]), 32'd0);
            chk($sformatf("rst_inflight[%0d]", i), 32'(infl_w[i]), 32'd0);
        end
        evq.delete();
        m_last = 1'b1;
        exp_cv = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc++;
    endtask

    initial begin
        int t0, nrdy;
        reset_n = 1'b0; en = 1'b1; av = 1'b0; bv = 1'b0;
        argb = '0; brgb = '0; atag = '0; btag = '0;
        cvh = '0; cvs = '0; cvv = '0;
        clr_stats();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_inflight[%0d]", i), 32'(infl_w[i]), 32'd0);
            chk($sformatf("reset_idle[%0d]", i), 32'(idle_w[i]), 32'd1);
            chk($sformatf("reset_cv[%0d]", i), 32'({cvr_w[i], cvg_w[i], cvb_w[i]}), 32'd0);
            chk($sformatf("reset_strobes[%0d]", i), 32'({aov_w[i], bov_w[i]}), 32'd0);
        end
        reset_n = 1'b1;
        cyc = 0;

        // Single A pixel issued at cycle 10.
        while (cyc < 10) run_cycle();
        av = 1'b1; argb = 24'hFF0000; atag = 20'h00123;
        t0 = cyc;
        run_cycle();
        drain(70);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("single_latency[%0d]", i), 32'(a_seen[i] - t0), 32'(lat(i) + 2));
            chk($sformatf("single_a_count[%0d]", i), 32'(a_cnt[i]), 32'd1);
            chk($sformatf("single_b_count[%0d]", i), 32'(b_cnt[i]), 32'd0);
        end

        // Grant table from a fresh reset, so the first contention goes to A.
        tbl[0]  = '{1, 1, 1, 1, 0};
        tbl[1]  = '{1, 1, 1, 0, 1};
        tbl[2]  = '{1, 1, 0, 1, 0};
        tbl[3]  = '{1, 1, 0, 1, 0};
        tbl[4]  = '{1, 1, 1, 0, 1};
        tbl[5]  = '{0, 1, 1, 0, 0};
        tbl[6]  = '{1, 0, 1, 0, 1};
        tbl[7]  = '{1, 1, 1, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 0, 1};
        tbl[10] = '{0, 1, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 1};
        do_reset();
        for (int v = 0; v < 12; v++) begin
            en = tbl[v].en; av = tbl[v].av; bv = tbl[v].bv;
            argb = 24'($urandom); brgb = 24'($urandom);
            atag = 20'($urandom); btag = 20'($urandom);
            run_cycle();
            chk($sformatf("tbl%0d_a_ready", v), 32'(smp_a), 32'(tbl[v].ea));
            chk($sformatf("tbl%0d_b_ready", v), 32'(smp_b), 32'(tbl[v].eb));
        end
        drain(70);

        // B streams alone for 30 cycles.
        clr_stats();
        nrdy = 0;
        for (int k = 0; k < 30; k++) begin
            bv = 1'b1; brgb = 24'($urandom); btag = 20'(k);
            run_cycle();
            if (smp_b) nrdy++;
        end
        drain(70);
        chk("stream_b_ready_cycles", 32'(nrdy), 32'd30);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("stream_b_count[%0d]", i), 32'(b_cnt[i]), 32'd30);
            chk($sformatf("stream_max_inflight[%0d]", i), 32'(max_infl[i]),
                32'((lat(i) + 1 < 30) ? lat(i) + 1 : 30));
        end

        // Enable dropped for 5 cycles under full contention.
        clr_stats();
        nrdy = 0;
        for (int k = 0; k < 20; k++) begin
            av = 1'b1; bv = 1'b1; en = !(k >= 8 && k < 13);
            argb = 24'($urandom); brgb = 24'($urandom);
            atag = 20'($urandom); btag = 20'($urandom);
            run_cycle();
            if (smp_a || smp_b) nrdy++;
        end
        drain(70);
        chk("enable_grant_cycles", 32'(nrdy), 32'd15);
        chk("enable_strobes", 32'(a_cnt[0] + b_cnt[0]), 32'd15);
        chk("enable_idle_after_drain", 32'(idle_w[0]), 32'd1);

        // Reset with pixels in flight: their results must never strobe.
        for (int k = 0; k < 10; k++) begin
            av = 1'b1; bv = 1'b1;
            argb = 24'($urandom); brgb = 24'($urandom);
            atag = 20'($urandom); btag = 20'($urandom);
            run_cycle();
        end
        do_reset();
        clr_stats();
        drain(70);
        for (int i = 0; i < NI; i++)
            chk($sformatf("discarded_strobes[%0d]", i), 32'(a_cnt[i] + b_cnt[i]), 32'd0);
        av = 1'b1; bv = 1'b1;
        run_cycle();
        chk("post_reset_first_grant_a", 32'(smp_a), 32'd1);
        drain(70);

        // Random traffic against the queue model.
        for (int k = 0; k < 600; k++) begin
            en = ($urandom_range(0, 9) != 0);
            av = ($urandom_range(0, 2) != 0);
            bv = ($urandom_range(0, 2) != 0);
            argb = 24'($urandom); brgb = 24'($urandom);
            atag = 20'($urandom); btag = 20'($urandom);
            run_cycle();
        end
        drain(70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
